// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC frame scheduler: channel geometry,
// FSM states, header marker and the packed-bus channel extractor.
package adc_pkg;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 12;

  localparam logic HDR_MARK = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    LO
  } state_t;

  // Channel i occupies bits [DATA_W*i +: DATA_W] of the packed sample bus.
  function automatic logic [DATA_W-1:0] ch_sample(
    input logic [NUM_CH*DATA_W-1:0] bus,
    input logic [2:0]               idx
  );
    return bus[idx*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/adc_ch_pick.sv
// Lowest-set-bit priority encoder over the channel mask; picks the next
// channel to serialise.
module adc_ch_pick
  import adc_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  output logic [2:0]        idx,
  output logic              any_set
);

  always_comb begin
    idx     = '0;
    any_set = |mask;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/adc_frame_scheduler.sv
// Snapshots enabled ADC channels on each sample tick and serialises them as
// header/low byte pairs over a valid/ready byte stream.
module adc_frame_scheduler
  import adc_pkg::*;
#(
  parameter int TICK_DIV = 6250
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     ENABLE,
  input  logic [NUM_CH-1:0]        CH_MASK,
  input  logic [NUM_CH*DATA_W-1:0] CH_DATA,
  output logic [7:0]               TX_DATA,
  output logic                     TX_VALID,
  input  logic                     TX_READY,
  output logic                     FRAME_DONE,
  output logic                     OVERRUN,
  output logic [7:0]               OVERRUN_CNT
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0]         tick_cnt;
  logic                     tick;
  state_t                   state, state_nx;
  logic [NUM_CH*DATA_W-1:0] snap;
  logic [NUM_CH-1:0]        rem_mask;
  logic [NUM_CH-1:0]        rem_clr;
  logic [NUM_CH-1:0]        pick_in;
  logic [2:0]               cur_ch;
  logic [2:0]               pick_idx;
  logic                     pick_any;
  logic                     ld_frame;
  logic                     xfer;
  logic [DATA_W-1:0]        cur_sample;

  assign tick = ENABLE && (tick_cnt == CNT_W'(TICK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the values present before the edge.
  always_ff @(posedge CLOCK) begin
    if (RESET || !ENABLE || tick) tick_cnt <= '0;
    else                          tick_cnt <= tick_cnt + CNT_W'(1);
  end

  assign xfer       = TX_VALID && TX_READY;
  assign rem_clr    = rem_mask & ~({{(NUM_CH-1){1'b0}}, 1'b1} << cur_ch);
  assign pick_in    = (state == IDLE) ? CH_MASK : rem_clr;
  assign cur_sample = ch_sample(snap, cur_ch);

  // One encoder serves both frame start (live mask) and channel advance
  // (remaining mask); the two uses are mutually exclusive by state.
  adc_ch_pick u_pick (
    .mask    (pick_in),
    .idx     (pick_idx),
    .any_set (pick_any)
  );

  // NOTE: every output of this block gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_nx   = state;
    TX_VALID   = 1'b0;
    TX_DATA    = '0;
    FRAME_DONE = 1'b0;
    ld_frame   = 1'b0;
    case (state)
      IDLE: begin
        if (tick && pick_any) begin
          ld_frame = 1'b1;
          state_nx = HDR;
        end
      end
      HDR: begin
        TX_VALID = 1'b1;
        TX_DATA  = {HDR_MARK, cur_ch, cur_sample[DATA_W-1:8]};
        if (TX_READY) state_nx = LO;
      end
      LO: begin
        TX_VALID = 1'b1;
        TX_DATA  = cur_sample[7:0];
        if (TX_READY) begin
          if (pick_any) begin
            state_nx = HDR;
          end else begin
            state_nx   = IDLE;
            FRAME_DONE = !RESET;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign OVERRUN = tick && (state != IDLE) && !RESET;

  // NOTE: the snapshot is cleared on reset so a sample from an aborted frame
  // can never reappear on the byte stream.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= IDLE;
      snap        <= '0;
      rem_mask    <= '0;
      cur_ch      <= '0;
      OVERRUN_CNT <= '0;
    end else begin
      state <= state_nx;
      if (ld_frame) begin
        snap     <= CH_DATA;
        rem_mask <= CH_MASK;
        cur_ch   <= pick_idx;
      end else if (xfer && state == LO) begin
        rem_mask <= rem_clr;
        cur_ch   <= pick_idx;
      end
      if (OVERRUN && OVERRUN_CNT != 8'hFF) OVERRUN_CNT <= OVERRUN_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Directed bench for adc_frame_scheduler: expected bytes go into a scoreboard
// queue and a negedge monitor pops and compares on every handshake.
module tb_adc_frame_scheduler;
  import adc_pkg::*;

  localparam int TD = 16;

  logic                     CLOCK = 1'b0;
  logic                     RESET;
  logic                     ENABLE;
  logic [NUM_CH-1:0]        CH_MASK;
  logic [NUM_CH*DATA_W-1:0] CH_DATA;
  logic [7:0]               TX_DATA;
  logic                     TX_VALID;
  logic                     TX_READY;
  logic                     FRAME_DONE;
  logic                     OVERRUN;
  logic [7:0]               OVERRUN_CNT;

  always #5 CLOCK = ~CLOCK;

  adc_frame_scheduler #(.TICK_DIV(TD)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .ENABLE      (ENABLE),
    .CH_MASK     (CH_MASK),
    .CH_DATA     (CH_DATA),
    .TX_DATA     (TX_DATA),
    .TX_VALID    (TX_VALID),
    .TX_READY    (TX_READY),
    .FRAME_DONE  (FRAME_DONE),
    .OVERRUN     (OVERRUN),
    .OVERRUN_CNT (OVERRUN_CNT)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   total      = 0;
  int   bad        = 0;
  int   ovr_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic done);
    exp_t e;
    e.data = d;
    e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  // Frame's first byte must appear exactly TD edges after the counter restarts.
  task automatic expect_start(input string name);
    step(TD - 1);
    check({name, "_valid_pre"}, 32'(TX_VALID), 32'd0);
    step(1);
    check({name, "_valid_rise"}, 32'(TX_VALID), 32'd1);
  endtask

  task automatic set_ch(input int i, input logic [11:0] v);
    CH_DATA[i*DATA_W +: DATA_W] = v;
  endtask

  // Monitor: scoreboard compare on handshakes, stall stability, pulse counting.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge CLOCK) begin
    exp_t e;
    if (prev_stall && !RESET) begin
      check("stall_valid_held", 32'(TX_VALID), 32'd1);
      check("stall_data_held", 32'(TX_DATA), 32'(prev_data));
    end
    if (TX_VALID === 1'b1 && TX_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: byte %0h arrived with nothing expected", TX_DATA);
      end else begin
        e = exp_q.pop_front();
        check("sb_byte", 32'(TX_DATA), 32'(e.data));
        check("sb_frame_done", 32'(FRAME_DONE), 32'(e.done));
      end
    end else if (FRAME_DONE === 1'b1) begin
      total++;
      bad++;
      $display("FAIL frame_done_no_xfer: FRAME_DONE=1 without handshake, expected 0");
    end
    if (OVERRUN === 1'b1) ovr_pulses++;
    prev_stall = (TX_VALID === 1'b1) && (TX_READY !== 1'b1) && !RESET;
    prev_data  = TX_DATA;
  end

  logic [11:0] ff_vals [NUM_CH] = '{12'h5A1, 12'h0F2, 12'hC33, 12'h704,
                                    12'h9E5, 12'h2B6, 12'hFF7, 12'h008};

  initial begin
    logic seen;
    RESET    = 1'b1;
    ENABLE   = 1'b0;
    CH_MASK  = '0;
    CH_DATA  = '0;
    TX_READY = 1'b1;
    step(3);
    check("rst_valid", 32'(TX_VALID), 32'd0);
    check("rst_data", 32'(TX_DATA), 32'd0);
    check("rst_frame_done", 32'(FRAME_DONE), 32'd0);
    check("rst_overrun", 32'(OVERRUN), 32'd0);
    check("rst_ovr_cnt", 32'(OVERRUN_CNT), 32'd0);
    RESET = 1'b0;
    step(1);

    // Two channels, full-rate ready: 8A BC A1 23 back to back.
    set_ch(0, 12'hABC);
    set_ch(2, 12'h123);
    CH_MASK = 8'h05;
    ENABLE  = 1'b1;
    push(8'h8A, 1'b0); push(8'hBC, 1'b0); push(8'hA1, 1'b0); push(8'h23, 1'b1);
    expect_start("t1");
    check("t1_first_byte", 32'(TX_DATA), 32'h8A);
    step(3);
    check("t1_done_4th", 32'(FRAME_DONE), 32'd1);
    check("t1_last_byte", 32'(TX_DATA), 32'h23);
    step(1);
    check("t1_idle_valid", 32'(TX_VALID), 32'd0);
    check("t1_ovr_cnt", 32'(OVERRUN_CNT), 32'd0);
    ENABLE = 1'b0;
    step(2);

    // Same frame, receiver stalls five cycles on the second byte.
    ENABLE = 1'b1;
    push(8'h8A, 1'b0); push(8'hBC, 1'b0); push(8'hA1, 1'b0); push(8'h23, 1'b1);
    expect_start("t2");
    step(1);
    TX_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t2_stall_data", 32'(TX_DATA), 32'hBC);
      check("t2_stall_valid", 32'(TX_VALID), 32'd1);
    end
    TX_READY = 1'b1;
    step(2);
    check("t2_done", 32'(FRAME_DONE), 32'd1);
    step(1);
    check("t2_idle_valid", 32'(TX_VALID), 32'd0);
    ENABLE = 1'b0;
    step(2);

    // Empty mask: ticks are ignored and never count as overruns.
    CH_MASK = 8'h00;
    ENABLE  = 1'b1;
    seen    = 1'b0;
    repeat (100) begin
      step(1);
      if (TX_VALID !== 1'b0) seen = 1'b1;
    end
    check("t4_no_valid", 32'(seen), 32'd0);
    check("t4_ovr_cnt", 32'(OVERRUN_CNT), 32'd0);
    ENABLE = 1'b0;
    step(2);

    // Snapshot isolation: CH3 and the mask change after the frame has started.
    set_ch(3, 12'h7FF);
    CH_MASK = 8'h08;
    ENABLE  = 1'b1;
    push(8'hB7, 1'b0); push(8'hFF, 1'b1);
    expect_start("t5");
    check("t5_hdr", 32'(TX_DATA), 32'hB7);
    set_ch(3, 12'h001);
    CH_MASK = 8'hFF;
    step(1);
    check("t5_lo_snap", 32'(TX_DATA), 32'hFF);
    check("t5_done", 32'(FRAME_DONE), 32'd1);
    step(1);
    check("t5_idle_valid", 32'(TX_VALID), 32'd0);
    ENABLE  = 1'b0;
    CH_MASK = 8'h00;
    step(2);

    // All channels, ready every third cycle: two mid-frame ticks overrun.
    for (int i = 0; i < NUM_CH; i++) begin
      set_ch(i, ff_vals[i]);
      push({1'b1, 3'(i), ff_vals[i][11:8]}, 1'b0);
      push(ff_vals[i][7:0], i == NUM_CH - 1);
    end
    ovr_pulses = 0;
    CH_MASK    = 8'hFF;
    ENABLE     = 1'b1;
    expect_start("t3");
    for (int k = 0; k < 2 * NUM_CH; k++) begin
      if (k > 0) begin
        TX_READY = 1'b0;
        step(2);
        TX_READY = 1'b1;
      end
      step(1);
    end
    ENABLE = 1'b0;
    check("t3_idle_valid", 32'(TX_VALID), 32'd0);
    check("t3_ovr_cnt", 32'(OVERRUN_CNT), 32'd2);
    check("t3_ovr_pulses", 32'(ovr_pulses), 32'd2);
    check("t3_all_bytes", 32'(exp_q.size()), 32'd0);
    step(2);

    // Reset while the LO byte is on the bus aborts the frame.
    CH_DATA = '0;
    set_ch(0, 12'hABC);
    set_ch(2, 12'h123);
    CH_MASK = 8'h05;
    ENABLE  = 1'b1;
    push(8'h8A, 1'b0); push(8'hBC, 1'b0);
    expect_start("t6");
    step(1);
    check("t6_in_lo", 32'(TX_DATA), 32'hBC);
    RESET = 1'b1;
    step(1);
    check("t6_rst_valid", 32'(TX_VALID), 32'd0);
    check("t6_rst_ovr_cnt", 32'(OVERRUN_CNT), 32'd0);
    RESET = 1'b0;
    push(8'h8A, 1'b0); push(8'hBC, 1'b0); push(8'hA1, 1'b0); push(8'h23, 1'b1);
    expect_start("t6_restart");
    step(3);
    check("t6_done", 32'(FRAME_DONE), 32'd1);
    step(1);
    ENABLE = 1'b0;
    step(2);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
